// File: rtl/o_table_ctrl.sv
// ============================================================================
// o_table_ctrl
//
// Purpose
//   Controller for the ODC offset table. It serialises two kinds of traffic
//   onto a single table access port:
//     * bulk loads from a byte-stream loader: 256 MSB-table bytes
//       (addresses 0x000..0x0FF) followed by 32 LSB-table bytes
//       (0x100..0x11F);
//     * single host reads and writes.
//   While a load is running, lookups are disabled and host requests wait.
//   Host reads wait for the table's read acknowledge. If no acknowledge
//   arrives within RD_TIMEOUT cycles, the read finishes with an error and
//   the data byte 8'hEE.
//
// Optional feature (macro O_TABLE_CTRL_CHKSUM_EN)
//   When defined, a modulo-256 sum of all 288 table bytes is accumulated.
//   After the table bytes, one extra checksum byte is taken from the stream
//   in state LD_SUM. This byte is not written to the table. A mismatch sets
//   load_err, which stays set until the next accepted load_start. When the
//   macro is undefined, load_err is tied low.
//
// Ports
//   pix_clk, rst_n        clock (rising edge); async active-low reset
//   host_req/host_wr      host request, 1 = write
//   host_addr/host_wdata  9-bit table address (bit8 = LSB table), write data
//   host_gnt              pulse in the cycle the host access reaches the table
//   host_rdata/rvalid/rerr  read result (registered), valid pulse, timeout flag
//   load_start            pulse that starts a bulk load
//   ld_valid/ld_data/ld_ready  loader stream; a byte moves on valid & ready
//   load_busy/done/err    load status
//   lkup_en               lookup enable, always the inverse of load_busy
//   tab_init              one-cycle table init strobe at the start of a load
//   o_reg_sel/o_reg_wr    table access select / write
//   o_reg_op_addr/o_reg_wr_data  table address / write data (held when idle)
//   table_mem_rd_data/rd_ok  table read data / read acknowledge
// ============================================================================
module o_table_ctrl #(
   parameter int RD_TIMEOUT = 15
) (
   input  logic       pix_clk,
   input  logic       rst_n,
   input  logic       host_req,
   input  logic       host_wr,
   input  logic [8:0] host_addr,
   input  logic [7:0] host_wdata,
   output logic       host_gnt,
   output logic [7:0] host_rdata,
   output logic       host_rvalid,
   output logic       host_rerr,
   input  logic       load_start,
   input  logic       ld_valid,
   input  logic [7:0] ld_data,
   output logic       ld_ready,
   output logic       load_busy,
   output logic       load_done,
   output logic       load_err,
   output logic       lkup_en,
   output logic       tab_init,
   output logic       o_reg_sel,
   output logic       o_reg_wr,
   output logic [8:0] o_reg_op_addr,
   output logic [7:0] o_reg_wr_data,
   input  logic [7:0] table_mem_rd_data,
   input  logic       table_mem_rd_ok
);

   // The timer counts 0..RD_TIMEOUT-1.
   localparam int TW = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT);
   localparam logic [TW-1:0] TMR_LAST = TW'(RD_TIMEOUT - 1);

   typedef enum logic [3:0] {
      IDLE,
      INIT,
      LD_MSB,
      LD_LSB,
`ifdef O_TABLE_CTRL_CHKSUM_EN
      LD_SUM,
`endif
      HOST_WR,
      HOST_RD,
      RD_WAIT,
      RD_DATA
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic [8:0]      addr_q;
   logic [7:0]      wdata_q;
   logic [7:0]      rdata_q, rdata_d;
   logic            rvalid_q, rvalid_d;
   logic            rerr_q, rerr_d;
   logic            done_q, done_d;
`ifdef O_TABLE_CTRL_CHKSUM_EN
   logic [7:0]      sum_q, sum_d;
   logic            err_q, err_d;
`endif

   // -------------------------------------------------------------------------
   // Next state and outputs
   // -------------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      tmr_d         = tmr_q;
      rdata_d       = rdata_q;
      rvalid_d      = 1'b0;
      rerr_d        = 1'b0;
      done_d        = 1'b0;
`ifdef O_TABLE_CTRL_CHKSUM_EN
      sum_d         = sum_q;
      err_d         = err_q;
`endif
      tab_init      = 1'b0;
      o_reg_sel     = 1'b0;
      o_reg_wr      = 1'b0;
      // The table address and write data hold their last value unless a
      // strobe drives them.
      o_reg_op_addr = addr_q;
      o_reg_wr_data = wdata_q;
      host_gnt      = 1'b0;
      ld_ready      = 1'b0;

      case (state_q)
         IDLE: begin
            // A load has priority over a host request in the same cycle.
            if (load_start) begin
               state_d = INIT;
`ifdef O_TABLE_CTRL_CHKSUM_EN
               err_d   = 1'b0;
`endif
            end else if (host_req) begin
               state_d = host_wr ? HOST_WR : HOST_RD;
            end
         end

         INIT: begin
            tab_init = 1'b1;
            cnt_d    = '0;
`ifdef O_TABLE_CTRL_CHKSUM_EN
            sum_d    = '0;
`endif
            state_d  = LD_MSB;
         end

         LD_MSB: begin
            ld_ready = 1'b1;
            if (ld_valid) begin
               o_reg_sel     = 1'b1;
               o_reg_wr      = 1'b1;
               o_reg_op_addr = {1'b0, cnt_q};
               o_reg_wr_data = ld_data;
               // Wraps naturally from 255 back to 0 for the LSB phase.
               cnt_d         = cnt_q + 8'd1;
`ifdef O_TABLE_CTRL_CHKSUM_EN
               sum_d         = sum_q + ld_data;
`endif
               if (cnt_q == 8'hFF) state_d = LD_LSB;
            end
         end

         LD_LSB: begin
            ld_ready = 1'b1;
            if (ld_valid) begin
               o_reg_sel     = 1'b1;
               o_reg_wr      = 1'b1;
               o_reg_op_addr = {4'b1000, cnt_q[4:0]};
               o_reg_wr_data = ld_data;
`ifdef O_TABLE_CTRL_CHKSUM_EN
               sum_d         = sum_q + ld_data;
`endif
               if (cnt_q == 8'd31) begin
                  cnt_d   = '0;
`ifdef O_TABLE_CTRL_CHKSUM_EN
                  state_d = LD_SUM;
`else
                  done_d  = 1'b1;
                  state_d = IDLE;
`endif
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end

`ifdef O_TABLE_CTRL_CHKSUM_EN
         LD_SUM: begin
            // The checksum byte is only compared. It is not written to the table.
            ld_ready = 1'b1;
            if (ld_valid) begin
               err_d   = (ld_data != sum_q);
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
`endif

         HOST_WR: begin
            o_reg_sel     = 1'b1;
            o_reg_wr      = 1'b1;
            o_reg_op_addr = host_addr;
            o_reg_wr_data = host_wdata;
            host_gnt      = 1'b1;
            state_d       = IDLE;
         end

         HOST_RD: begin
            o_reg_sel     = 1'b1;
            o_reg_op_addr = host_addr;
            host_gnt      = 1'b1;
            tmr_d         = '0;
            state_d       = RD_WAIT;
         end

         RD_WAIT: begin
            // An acknowledge in the last allowed cycle still wins over the timeout.
            if (table_mem_rd_ok) begin
               tmr_d   = '0;
               state_d = RD_DATA;
            end else if (tmr_q == TMR_LAST) begin
               tmr_d    = '0;
               rdata_d  = 8'hEE;
               rvalid_d = 1'b1;
               rerr_d   = 1'b1;
               state_d  = IDLE;
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end

         RD_DATA: begin
            // The table returns its data in the cycle after rd_ok.
            rdata_d  = table_mem_rd_data;
            rvalid_d = 1'b1;
            state_d  = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   assign load_busy = (state_q == INIT) || (state_q == LD_MSB) || (state_q == LD_LSB)
`ifdef O_TABLE_CTRL_CHKSUM_EN
                      || (state_q == LD_SUM)
`endif
                      ;
   assign lkup_en     = ~load_busy;
   assign host_rdata  = rdata_q;
   assign host_rvalid = rvalid_q;
   assign host_rerr   = rerr_q;
   assign load_done   = done_q;
`ifdef O_TABLE_CTRL_CHKSUM_EN
   assign load_err    = err_q;
`else
   assign load_err    = 1'b0;
`endif

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         tmr_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         rerr_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         tmr_q    <= tmr_d;
         addr_q   <= o_reg_op_addr;
         wdata_q  <= o_reg_wr_data;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         rerr_q   <= rerr_d;
         done_q   <= done_d;
      end
   end

`ifdef O_TABLE_CTRL_CHKSUM_EN
   always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= '0;
         err_q <= 1'b0;
      end else begin
         sum_q <= sum_d;
         err_q <= err_d;
      end
   end
`endif

endmodule
